// File: rtl/xor_checksum_checker.sv
// ---------------------------------------------------------------------------
// xor_checksum_checker
//
// Receives a packet of `len` 32-bit data words followed by one checksum word
// and checks that the checksum equals the bitwise XOR of the data words.
//
// Optional feature: define XOR_CHK_ERR_COUNT_EN to build a saturating 8-bit
// counter of mismatching packets. Without it, err_count is tied to zero and
// no counter logic is present.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset_n    : asynchronous active-low reset
//   start      : begin a packet check (only looked at in IDLE)
//   len        : number of data words before the checksum, sampled with start
//   abort      : synchronous return to IDLE from any state, highest priority
//   in_valid   : in_data carries a word
//   in_data    : data or checksum word
//   in_ready   : block accepts in_data this cycle (DATA or CHECK only)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse when a check completes
//   match      : received checksum equals computed XOR, valid with done
//   result     : XOR of the last completed packet's data words
//   err_count  : number of mismatching packets (saturates at 255)
// ---------------------------------------------------------------------------
module xor_checksum_checker #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [31:0]      result,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Saturating increment used by the mismatch counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) return v;
    return v + 8'd1;
  endfunction

  state_t           state, state_nxt;
  logic [31:0]      acc, acc_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             match_nxt;
  logic [31:0]      result_nxt;
  logic             accept;

  // Handshake outputs are pure functions of the state so in_ready can never
  // combinationally follow in_valid.
  assign in_ready = (state == S_DATA) || (state == S_CHECK);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    match_nxt  = match;
    result_nxt = result;
    if (abort) begin
      // Abort wins over start and over a same-cycle accept; match/result
      // keep the last completed packet's values.
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc_nxt   = '0;
            cnt_nxt   = len;
            state_nxt = (len != '0) ? S_DATA : S_CHECK;
          end
        end
        S_DATA: begin
          if (accept) begin
            acc_nxt = acc ^ in_data;
            cnt_nxt = cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) state_nxt = S_CHECK;
          end
        end
        S_CHECK: begin
          if (accept) begin
            match_nxt  = (acc == in_data);
            result_nxt = acc;
            state_nxt  = S_DONE;
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      match  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      match  <= match_nxt;
      result <= result_nxt;
    end
  end

`ifdef XOR_CHK_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  // match is already registered when DONE is entered, so the DONE cycle is
  // where the completed packet's outcome is counted. An abort landing in that
  // cycle suppresses the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if ((state == S_DONE) && !match && !abort) begin
      err_cnt_q <= sat_inc8(err_cnt_q);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_xor_checksum_checker.sv
module tb_xor_checksum_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, busy, done, match;
  logic [31:0] result;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xor_checksum_checker #(.LEN_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .done(done), .match(match), .result(result), .err_count(err_count)
  );

`ifdef XOR_CHK_ERR_COUNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: a packet is "open" from start until its checksum is
  // taken; words still owed are counted as len+1 and data words are kept in a
  // queue so the expected XOR is folded only when the checksum arrives.
  bit          m_open = 0;
  bit          m_fin = 0;
  int          m_owed = 0;
  logic [31:0] m_words[$];
  bit          m_match = 0;
  logic [31:0] m_result = '0;
  int          m_err = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_open = 0; m_fin = 0; m_owed = 0; m_words.delete();
      m_match = 0; m_result = '0; m_err = 0;
    end else if (abort) begin
      m_open = 0; m_fin = 0;
    end else if (m_fin) begin
      if (ERR_EN != 0 && !m_match && m_err < 255) m_err++;
      m_fin = 0;
    end else if (!m_open) begin
      if (start) begin
        m_open = 1; m_owed = int'(len) + 1; m_words.delete();
      end
    end else if (in_valid) begin
      if (m_owed > 1) begin
        m_words.push_back(in_data);
        m_owed--;
      end else begin
        logic [31:0] x;
        x = '0;
        foreach (m_words[i]) x ^= m_words[i];
        m_result = x;
        m_match  = (x == in_data);
        m_open = 0; m_fin = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_open});
    chk("busy",     {31'd0, busy},     {31'd0, (m_open || m_fin)});
    chk("done",     {31'd0, done},     {31'd0, m_fin});
    chk("match",    {31'd0, match},    {31'd0, m_match});
    chk("result",   result,            m_result);
    chk("err_count",{24'd0, err_count}, 32'(m_err));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0;
  endtask

  // Present a word until it is accepted; random idle gaps when stall=1.
  task automatic send(input logic [31:0] w, input bit stall);
    bit r;
    int n;
    if (stall) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    in_valid = 1'b1; in_data = w;
    n = 0;
    do begin
      @(negedge clk); r = in_ready;
      tick();
      n++;
    end while (!r && n < 50);
    if (!r) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    int err0;
    repeat (3) tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_result", result, 32'd0);
    reset_n = 1'b1;
    tick();

    // Good packet: done and literal values right after the checksum accept.
    do_start(8'd3);
    send(32'h0000_00FF, 0); send(32'h0000_FF00, 0); send(32'h00FF_0000, 0);
    send(32'h00FF_FFFF, 0);
    chk("good_done", {31'd0, done}, 32'd1);
    chk("good_match", {31'd0, match}, 32'd1);
    chk("good_result", result, 32'h00FF_FFFF);
    tick();
    chk("good_done_once", {31'd0, done}, 32'd0);

    // Bad packet.
    err0 = err_count;
    do_start(8'd3);
    send(32'h0000_00FF, 0); send(32'h0000_FF00, 0); send(32'h00FF_0000, 0);
    send(32'h00FF_FFFE, 0);
    chk("bad_match", {31'd0, match}, 32'd0);
    chk("bad_result", result, 32'h00FF_FFFF);
    tick();
    chk("bad_err_inc", 32'(err_count), 32'(err0 + ERR_EN));

    // len = 0.
    do_start(8'd0);
    send(32'h0, 0);
    chk("len0_match", {31'd0, match}, 32'd1);
    chk("len0_result", result, 32'd0);
    tick();
    do_start(8'd0);
    send(32'h1, 0);
    chk("len0_bad_match", {31'd0, match}, 32'd0);
    tick();

    // Stalled len=5 with a start pulse during DATA that must be ignored.
    do_start(8'd5);
    send(32'h1, 1); send(32'h2, 1);
    start = 1'b1; len = 8'd0; tick(); start = 1'b0;
    send(32'h4, 1); send(32'h8, 1); send(32'h10, 1);
    send(32'h1F, 1);
    chk("stall_done", {31'd0, done}, 32'd1);
    chk("stall_match", {31'd0, match}, 32'd1);
    chk("stall_result", result, 32'h0000_001F);
    tick();

    // Abort after 2 of 4 words, with a same-cycle valid word.
    do_start(8'd4);
    send(32'hAAAA_0000, 0); send(32'h0000_5555, 0);
    abort = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_match", {31'd0, match}, 32'd1);
    chk("abort_result", result, 32'h0000_001F);

    // Abort beats start in IDLE.
    start = 1'b1; abort = 1'b1; len = 8'd2; tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_vs_start", {31'd0, busy}, 32'd0);

    // Reset in the middle of a packet.
    do_start(8'd3);
    send(32'h0F0F_0F0F, 0);
    reset_n = 1'b0; #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    // Words without a fresh start are not taken.
    in_valid = 1'b1; in_data = 32'h5; tick(); tick(); in_valid = 1'b0;
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    // Saturation: 260 mismatching len=0 packets.
    for (int i = 0; i < 260; i++) begin
      do_start(8'd0);
      send(32'h1, 0);
      tick();
    end
    chk("sat_err", {24'd0, err_count}, (ERR_EN != 0) ? 32'd255 : 32'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
